// File: rtl/key_pkg.sv
// key_pkg: one-hot FSM state constants and counter-width helper shared by the key filter blocks.
package key_pkg;
  localparam logic [3:0] S_IDLE    = 4'b0001;
  localparam logic [3:0] S_FILTER0 = 4'b0010;
  localparam logic [3:0] S_DOWN    = 4'b0100;
  localparam logic [3:0] S_FILTER1 = 4'b1000;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/key_filter_chan.sv
// key_filter_chan: one key channel -- synchroniser, debounce FSM, long-press and auto-repeat timing.
module key_filter_chan import key_pkg::*; #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic key_long,
  output logic key_repeat
);
  localparam logic REL = ACTIVE_LOW != 0;
  localparam int DW = cnt_w(DEB_CYCLES - 1);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam int RW = cnt_w(REPEAT_CYCLES - 1);
  logic s1, s2, s3;
  logic [3:0] st;
  logic [DW-1:0] deb;
  logic [HW-1:0] hold;
  logic [RW-1:0] rcnt;
  logic press_e, rel_e;
  assign press_e = (s2 != REL) && (s3 == REL);
  assign rel_e   = (s2 == REL) && (s3 != REL);
  // Commit compares one below the final count so the state updates on the edge the counter reaches DEB_CYCLES-1.
  // The hold counter saturates at LONG_CYCLES, which makes key_long fire at most once per press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {s1, s2, s3} <= {3{REL}};
      st <= S_IDLE;
      deb <= '0;
      hold <= '0;
      rcnt <= '0;
      key_flag <= 1'b0;
      key_state <= REL;
      key_long <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      s3 <= s2;
      key_flag <= 1'b0;
      key_long <= 1'b0;
      key_repeat <= 1'b0;
      deb <= (st == S_FILTER0 || st == S_FILTER1) && deb != DW'(DEB_CYCLES - 1) ? deb + 1'b1 : deb;
      case (st)
        S_IDLE: if (press_e) begin
          st <= S_FILTER0;
          deb <= '0;
        end
        S_FILTER0: if (rel_e) st <= S_IDLE;
        else if (deb == DW'(DEB_CYCLES - 2)) begin
          st <= S_DOWN;
          key_flag <= 1'b1;
          key_state <= ~REL;
          hold <= '0;
          rcnt <= '0;
        end
        S_DOWN: begin
          st <= rel_e ? S_FILTER1 : S_DOWN;
          if (rel_e) deb <= '0;
          if (hold != HW'(LONG_CYCLES)) hold <= hold + 1'b1;
          key_long <= hold == HW'(LONG_CYCLES - 1);
          if (hold == HW'(LONG_CYCLES - 1)) rcnt <= '0;
          else if (hold == HW'(LONG_CYCLES) && REPEAT_EN != 0) begin
            rcnt <= rcnt == RW'(REPEAT_CYCLES - 1) ? '0 : rcnt + 1'b1;
            key_repeat <= rcnt == RW'(REPEAT_CYCLES - 1);
          end
        end
        S_FILTER1: if (press_e) st <= S_DOWN;
        else if (deb == DW'(DEB_CYCLES - 2)) begin
          st <= S_IDLE;
          key_flag <= 1'b1;
          key_state <= REL;
        end
        default: begin
          st <= S_IDLE;
          key_state <= REL;
          deb <= '0;
          hold <= '0;
          rcnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/key_filter_multi.sv
// key_filter_multi: N_KEYS independent debounced key channels with press/release, long-press and repeat pulses.
module key_filter_multi import key_pkg::*; #(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_flag,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_any
);
  if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES) begin : g_bad_param
    $error("key_filter_multi: need DEB_CYCLES >= 2 and LONG_CYCLES > DEB_CYCLES");
  end
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_filter_chan #(
      .DEB_CYCLES(DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN(REPEAT_EN),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .key_in(key_in[i]),
      .key_flag(key_flag[i]),
      .key_state(key_state[i]),
      .key_long(key_long[i]),
      .key_repeat(key_repeat[i])
    );
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_any <= 1'b0;
    else key_any <= |key_flag;
  end
endmodule

// File: doc/key_filter_multi.md
KEY_FILTER_MULTI -- requirements
Module: key_filter_multi

Interface
REQ-001 Parameter N_KEYS, default 4, number of independent key channels (1..32).
REQ-002 Parameter DEB_CYCLES, default 1_000_000, debounce window in clk cycles (20 ms at 50 MHz), range 2..2^24.
REQ-003 Parameter LONG_CYCLES, default 50_000_000, hold time before a long-press pulse, greater than DEB_CYCLES.
REQ-004 Parameter REPEAT_CYCLES, default 10_000_000, auto-repeat period after a long press, range 2..2^26.
REQ-005 Parameter REPEAT_EN, default 1, enables auto-repeat pulses when 1.
REQ-006 Parameter ACTIVE_LOW, default 1: 1 = pressed key reads 0, 0 = pressed key reads 1.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 key_in  input  N_KEYS  raw, asynchronous key pins.
REQ-010 key_flag  output  N_KEYS  one-cycle pulse per channel on each committed press or release.
REQ-011 key_state  output  N_KEYS  debounced pin level per channel.
REQ-012 key_long  output  N_KEYS  one-cycle pulse when a press has been held LONG_CYCLES.
REQ-013 key_repeat  output  N_KEYS  one-cycle pulse every REPEAT_CYCLES after key_long while the key is still held.
REQ-014 key_any  output  1  registered OR of key_flag, one cycle later than key_flag.

Function
REQ-015 Each channel SHALL synchronise key_in with two flip-flops, then register the result once more for edge detection; "press edge" and "release edge" are defined on the synchronised signal and respect ACTIVE_LOW.
REQ-016 Each channel SHALL run an FSM with states IDLE, FILTER0, DOWN and FILTER1, one-hot encoded.
REQ-017 IDLE -> FILTER0 on a press edge; the debounce counter is cleared to 0 on entry and increments every cycle while in FILTER0 or FILTER1.
REQ-018 FILTER0: a release edge SHALL return the channel to IDLE with no output pulse; if the counter reaches DEB_CYCLES-1, the channel SHALL go to DOWN, pulse key_flag and set key_state to the pressed level.
REQ-019 DOWN -> FILTER1 on a release edge; FILTER1: a press edge returns to DOWN silently; if the counter reaches DEB_CYCLES-1, the channel goes to IDLE, pulses key_flag and sets key_state to the released level.
REQ-020 Latency: a key_in change first sampled at edge 0 and stable thereafter SHALL update key_state, with key_flag high, after edge DEB_CYCLES+1; the latency is identical for press and release and for all channels.
REQ-021 The hold counter SHALL clear on entry to DOWN, increment only in DOWN, and pause (not clear) in FILTER1.
REQ-022 key_long SHALL pulse when the hold counter reaches LONG_CYCLES-1, at most once per press.
REQ-023 With REPEAT_EN=1, key_repeat SHALL pulse every REPEAT_CYCLES cycles after the key_long pulse while in DOWN; with REPEAT_EN=0 it stays 0.
REQ-024 Once a release commits, no key_long or key_repeat pulse SHALL follow until the next committed press.
REQ-025 Counter widths SHALL be $clog2(max value + 1); counters saturate and never wrap.
REQ-026 Channels SHALL be fully independent; simultaneous events on any channels SHALL all be reported in the same cycle.
REQ-027 An illegal FSM encoding SHALL recover to IDLE, with the channel's outputs set to their reset values, on the next edge.

Reset
REQ-028 When reset is asserted: key_flag, key_long, key_repeat, key_any = 0; key_state = released level ({N_KEYS{ACTIVE_LOW}}); all FSMs in IDLE; counters and synchronisers cleared to the released level.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL abort the operation immediately, with no pulse issued at deassertion.

Structure
REQ-030 The FSM state constants and the counter-width function SHALL live in the shared package key_pkg.
REQ-031 The per-channel logic SHALL be sub-module key_filter_chan, instantiated N_KEYS times by generate; the top level holds only key_any.
REQ-032 Parameter violations (LONG_CYCLES <= DEB_CYCLES, DEB_CYCLES < 2) SHALL raise an elaboration error.

Verification (N_KEYS=4, DEB_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=16, ACTIVE_LOW=1)
REQ-033 Clean press: key_in[0] 1->0 sampled at edge 0 -> key_flag[0] high after edge 9, key_state[0]=0, key_any high after edge 10.
REQ-034 Bounce: key_in[1] low for 3 cycles then high -> no key_flag[1], key_state[1] stays 1, FSM back in IDLE.
REQ-035 Long hold: key_in[2] held low 120 cycles -> key_flag once, key_long 40 cycles after key_flag, then key_repeat at +16 and +32 cycles after key_long.
REQ-036 Release glitch: while held, key_in[2] high for 4 cycles -> no release flag, hold counter paused, key_long timing shifted by exactly the FILTER1 duration.
REQ-037 Simultaneous: all 4 keys pressed on the same edge -> key_flag=4'b1111 in one cycle, key_any a single pulse.
REQ-038 Reset mid-debounce: reset asserted at cycle 5 of FILTER0 -> outputs at reset values at once, no key_flag after deassertion until a new valid press.
